sipo_rx_word_controller: RTL and testbench

- Sequences a serial-in/parallel-out shift stage that receives framed serial data.
- Counts valid serial bits and detects word completion, then transfers each completed word into an output holding register.
- The holding register sits behind a valid/ready handshake, so the next word can shift in while the previous one waits.
- Placed between a serial line front-end and a parallel-word consumer; also reports overrun and framing errors.

---
 rtl/sipo_rx_word_controller_pkg.sv | 5 +
 rtl/sipo_rx_shift_stage.sv | 30 +++
 rtl/sipo_rx_word_controller.sv | 80 ++++++++
 tb/tb_sipo_rx_word_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_word_controller_pkg.sv
// sipo_rx_word_controller_pkg: shared state encoding and default word width for the SIPO receiver
package sipo_rx_word_controller_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam int DEFAULT_WORD_WIDTH = 16;
endpackage

// File: rtl/sipo_rx_shift_stage.sv
// sipo_rx_shift_stage: serial-in shift register with synchronous clear and selectable shift direction
module sipo_rx_shift_stage
    import sipo_rx_word_controller_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  Clk_In,
    input  logic                  Reset_N_In,
    input  logic                  Shift_En_In,
    input  logic                  Serial_Data_In,
    input  logic                  Clear_In,
    output logic [WORD_WIDTH-1:0] Word_Out
);
    logic [WORD_WIDTH-1:0] base;
    logic [WORD_WIDTH-1:0] word_next;

    // Clear applies before the shift so a same-cycle bit starts a fresh word
    always_comb begin
        base      = Clear_In ? '0 : Word_Out;
        word_next = !Shift_En_In ? base :
                    MSB_FIRST ? {base[WORD_WIDTH-2:0], Serial_Data_In} :
                                {Serial_Data_In, base[WORD_WIDTH-1:1]};
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) Word_Out <= '0;
        else Word_Out <= word_next;
    end
endmodule

// File: rtl/sipo_rx_word_controller.sv
// sipo_rx_word_controller: framed serial receiver with word holding register, valid/ready output and error status
module sipo_rx_word_controller
    import sipo_rx_word_controller_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit CONTINUOUS = 1'b0,
    parameter int CNT_WIDTH  = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  Clk_In,
    input  logic                  Reset_N_In,
    input  logic                  Enable_In,
    input  logic                  Start_In,
    input  logic                  Serial_Valid_In,
    input  logic                  Serial_Data_In,
    output logic [WORD_WIDTH-1:0] Word_Data_Out,
    output logic                  Word_Valid_Out,
    input  logic                  Word_Ready_In,
    output logic                  Busy_Out,
    output logic [CNT_WIDTH-1:0]  Bit_Count_Out,
    output logic                  Overrun_Out,
    output logic                  Frame_Error_Out,
    input  logic                  Clear_Status_In
);
    state_t                state, state_next;
    logic [CNT_WIDTH-1:0]  cnt, cnt_inc, cnt_next;
    logic [WORD_WIDTH-1:0] sr, full_word;
    logic                  start_ev, take_bit, done, clear_sr, fe_next, load, drop;

    sipo_rx_shift_stage #(
        .WORD_WIDTH(WORD_WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .Clk_In        (Clk_In),
        .Reset_N_In    (Reset_N_In),
        .Shift_En_In   (take_bit),
        .Serial_Data_In(Serial_Data_In),
        .Clear_In      (clear_sr),
        .Word_Out      (sr)
    );

    always_comb begin
        start_ev   = Enable_In & Start_In;
        take_bit   = Enable_In & Serial_Valid_In & ((state == SHIFT) | Start_In);
        cnt_inc    = (start_ev ? '0 : cnt) + CNT_WIDTH'(take_bit);
        done       = take_bit & (cnt_inc == CNT_WIDTH'(WORD_WIDTH));
        state_next = !Enable_In ? IDLE :
                     done ? (CONTINUOUS ? SHIFT : IDLE) :
                     ((state == SHIFT) | Start_In) ? SHIFT : IDLE;
        cnt_next   = (!Enable_In | done) ? '0 : cnt_inc;
        clear_sr   = !Enable_In | start_ev;
        fe_next    = start_ev & (state == SHIFT) & (cnt != '0);
        // Completion never coincides with a restart (width >= 2), so the last bit always extends sr
        full_word  = MSB_FIRST ? {sr[WORD_WIDTH-2:0], Serial_Data_In} :
                                 {Serial_Data_In, sr[WORD_WIDTH-1:1]};
        load       = done & (!Word_Valid_Out | Word_Ready_In);
        drop       = done & Word_Valid_Out & !Word_Ready_In;
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state           <= IDLE;
            cnt             <= '0;
            Word_Data_Out   <= '0;
            Word_Valid_Out  <= 1'b0;
            Overrun_Out     <= 1'b0;
            Frame_Error_Out <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            Frame_Error_Out <= fe_next;
            if (load) Word_Data_Out <= full_word;
            Word_Valid_Out  <= load | (Word_Valid_Out & !Word_Ready_In);
            Overrun_Out     <= drop | (Overrun_Out & !Clear_Status_In);
        end
    end

    assign Busy_Out      = (state == SHIFT);
    assign Bit_Count_Out = cnt;
endmodule

// File: tb/tb_sipo_rx_word_controller.sv
// tb_sipo_rx_word_controller: two-configuration scoreboard bench with a bit-list reference model
module tb_sipo_rx_word_controller;
    localparam int W = 16;
    localparam int C = 5;

    logic clk = 0, rst_n = 0, en = 0, start = 0, sv = 0, sd = 0, rdy = 0, clr = 0;
    logic [W-1:0] wd[2];
    logic [C-1:0] bc[2];
    logic         wv[2], busy[2], ov[2], fe[2];

    int checks = 0, passed = 0;

    logic [W-1:0] m_bits[2], m_hw[2];
    int           m_cnt[2];
    bit           m_busy[2], m_hv[2], m_ov[2], m_fe[2];
    logic [W-1:0] exp_q0[$], exp_q1[$];

    always #5 clk = ~clk;

    sipo_rx_word_controller #(.WORD_WIDTH(W), .MSB_FIRST(1), .CONTINUOUS(0)) u0 (
        .Clk_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Start_In(start),
        .Serial_Valid_In(sv), .Serial_Data_In(sd), .Word_Data_Out(wd[0]),
        .Word_Valid_Out(wv[0]), .Word_Ready_In(rdy), .Busy_Out(busy[0]),
        .Bit_Count_Out(bc[0]), .Overrun_Out(ov[0]), .Frame_Error_Out(fe[0]),
        .Clear_Status_In(clr));

    sipo_rx_word_controller #(.WORD_WIDTH(W), .MSB_FIRST(0), .CONTINUOUS(1)) u1 (
        .Clk_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Start_In(start),
        .Serial_Valid_In(sv), .Serial_Data_In(sd), .Word_Data_Out(wd[1]),
        .Word_Valid_Out(wv[1]), .Word_Ready_In(rdy), .Busy_Out(busy[1]),
        .Bit_Count_Out(bc[1]), .Overrun_Out(ov[1]), .Frame_Error_Out(fe[1]),
        .Clear_Status_In(clr));

    function automatic logic [W-1:0] rev16(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Lane 0 is MSB-first single-word, lane 1 is LSB-first continuous; a word is a list of bits in arrival order
    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 0; m_cnt[k] = 0; m_hv[k] = 0; m_hw[k] = '0;
                m_ov[k] = 0; m_fe[k] = 0; m_bits[k] = '0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin : lane
                bit done, drop;
                logic [W-1:0] nw;
                done = 0; nw = '0; m_fe[k] = 0;
                if (!en) begin
                    m_busy[k] = 0; m_cnt[k] = 0;
                end else begin
                    if (start) begin
                        m_fe[k] = m_busy[k] && m_cnt[k] > 0;
                        m_busy[k] = 1; m_cnt[k] = 0;
                    end
                    if (m_busy[k] && sv) begin
                        m_bits[k][m_cnt[k]] = sd;
                        m_cnt[k]++;
                        if (m_cnt[k] == W) begin
                            for (int i = 0; i < W; i++) nw[k == 0 ? W-1-i : i] = m_bits[k][i];
                            done = 1; m_cnt[k] = 0; m_busy[k] = (k == 1);
                        end
                    end
                end
                drop = done && m_hv[k] && !rdy;
                m_ov[k] = drop ? 1'b1 : clr ? 1'b0 : m_ov[k];
                if (done && !drop) begin
                    m_hw[k] = nw; m_hv[k] = 1;
                    if (k == 0) exp_q0.push_back(nw); else exp_q1.push_back(nw);
                end else if (m_hv[k] && rdy) m_hv[k] = 0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        for (int k = 0; k < 2; k++) begin : mon_lane
            logic [W-1:0] e;
            chk($sformatf("valid%0d", k), 32'(wv[k]), 32'(m_hv[k]));
            chk($sformatf("data%0d", k), 32'(wd[k]), 32'(m_hw[k]));
            chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_busy[k]));
            chk($sformatf("count%0d", k), 32'(bc[k]), 32'(m_cnt[k]));
            chk($sformatf("overrun%0d", k), 32'(ov[k]), 32'(m_ov[k]));
            chk($sformatf("frame_err%0d", k), 32'(fe[k]), 32'(m_fe[k]));
            if (wv[k] && rdy) begin
                if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    checks++;
                    $display("FAIL scoreboard%0d: accepted word %0h with no word expected", k, wd[k]);
                end else begin
                    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk($sformatf("scoreboard%0d", k), 32'(wd[k]), 32'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit s, input bit v, input bit d);
        start = s; sv = v; sd = d;
        tick();
        start = 0; sv = 0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit with_start);
        for (int i = 0; i < W; i++) drive(with_start && i == 0, 1'b1, w[W-1-i]);
    endtask

    task automatic accept();
        rdy = 1;
        tick();
        rdy = 0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_data%0d", tag, k), 32'(wd[k]), 0);
            chk($sformatf("%s_valid%0d", tag, k), 32'(wv[k]), 0);
            chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 0);
            chk($sformatf("%s_count%0d", tag, k), 32'(bc[k]), 0);
            chk($sformatf("%s_ovr%0d", tag, k), 32'(ov[k]), 0);
            chk($sformatf("%s_fe%0d", tag, k), 32'(fe[k]), 0);
        end
    endtask

    initial begin
        logic [W-1:0] w;
        rst_n = 0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1; en = 1;
        tick();

        send_word(16'hA5C3, 1);
        chk("t1_valid_after_last", 32'(wv[0]), 1);
        chk("t1_word_msb", 32'(wd[0]), 32'h0000A5C3);
        chk("t1_idle_after", 32'(busy[0]), 0);
        chk("t1_word_lsb", 32'(wd[1]), 32'h0000C3A5);
        accept();

        send_word(16'h1234, 1);
        send_word(16'hBEEF, 0);
        chk("t3_retained", 32'(wd[1]), 32'(rev16(16'h1234)));
        chk("t3_overrun", 32'(ov[1]), 1);
        clr = 1;
        tick();
        clr = 0;
        chk("t3_overrun_cleared", 32'(ov[1]), 0);

        w = 16'hBEEF;
        for (int i = 0; i < W; i++) begin
            rdy = (i == W-1);
            drive(i == 0, 1'b1, w[W-1-i]);
        end
        rdy = 0;
        chk("t4_valid_held", 32'(wv[1]), 1);
        chk("t4_new_word", 32'(wd[1]), 32'(rev16(16'hBEEF)));
        chk("t4_no_overrun", 32'(ov[1]), 0);
        chk("t4_word_msb", 32'(wd[0]), 32'h0000BEEF);
        accept();

        for (int i = 0; i < 7; i++) drive(i == 0, 1'b1, 1'(i));
        w = 16'h5A0F;
        for (int i = 0; i < W; i++) begin
            drive(i == 0, 1'b1, w[W-1-i]);
            if (i == 0) begin
                chk("t5_fe_pulse", 32'(fe[0]), 1);
                chk("t5_count_restart", 32'(bc[0]), 1);
            end
            if (i == 1) chk("t5_fe_single", 32'(fe[0]), 0);
        end
        chk("t5_word", 32'(wd[0]), 32'h00005A0F);
        accept();

        for (int i = 0; i < 5; i++) drive(i == 0, 1'b1, 1'b1);
        en = 0;
        tick();
        chk("t6_disable_count", 32'(bc[0]), 0);
        chk("t6_disable_fe", 32'(fe[0]), 0);
        en = 1;

        send_word(16'h0F0F, 1);
        for (int i = 0; i < 9; i++) drive(i == 0, 1'b1, 1'b1);
        @(posedge clk);
        #3 rst_n = 0;
        #1 check_all_zero("async");
        tick();
        rst_n = 1;
        tick();
        send_word(16'h3C96, 1);
        chk("t7_resume", 32'(wd[0]), 32'h00003C96);
        accept();

        for (int n = 0; n < 3000; n++) begin
            en    = ($urandom_range(0, 31) != 0);
            start = ($urandom_range(0, 19) == 0);
            sv    = ($urandom_range(0, 3) != 0);
            sd    = 1'($urandom_range(0, 1));
            rdy   = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            tick();
        end
        en = 1; start = 0; sv = 0; rdy = 0; clr = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
